// File: rtl/parity_nibble_rx.sv
// Serial receiver for start + 4 data (LSB first) + parity + stop frames.
// Oversamples an asynchronous idle-high line and reports each frame with a one-cycle valid strobe.
`timescale 1ns/1ps
module parity_nibble_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // The edge-detect cycle in IDLE already counts toward the half-bit wait.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          stop_q, stop_d;
  logic          done_q, done_d;
  logic [3:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          tick_half, tick_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_dly_q  <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b1;
      done_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign tick_half = (cnt_q == HALF_LAST);
  assign tick_bit  = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    // Result is published one clock after the stop sample, independent of the FSM.
    if (done_q) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      perr_d  = par_q ^ (^shift_q) ^ PARITY_ODD;
      ferr_d  = ~stop_q;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_dly_q && !rx_sync_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_half) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tick_bit) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          if (idx_q == 2'd3) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tick_bit) begin
          cnt_d   = '0;
          par_d   = rx_sync_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tick_bit) begin
          cnt_d   = '0;
          stop_d  = rx_sync_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_parity_nibble_rx.sv
// Scoreboard bench for parity_nibble_rx: frames are queued as they are driven and
// checked when valid fires; a second instance with odd parity shares the line.
`timescale 1ns/1ps
module tb_parity_nibble_rx;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] data, data2;
  logic       valid, valid2;
  logic       parity_err, parity_err2;
  logic       frame_err, frame_err2;
  logic       busy, busy2;

  parity_nibble_rx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  parity_nibble_rx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data2), .valid(valid2),
    .parity_err(parity_err2), .frame_err(frame_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       pe;
    logic       fe;
    int         fall;
    bit         chk_lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  int         valid_count = 0;
  logic       prev_valid = 1'b0;
  logic [3:0] last_data = 4'h0;
  logic       last_pe = 1'b0;
  logic       last_fe = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Output monitor: pops the scoreboard on every valid strobe.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      valid_count++;
      checks++;
      if (prev_valid === 1'b1) begin
        errors++;
        $display("FAIL valid_consecutive: valid high two cycles in a row at cycle %0d", cycle);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_in_result: busy=%b required 0", busy);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: data=%h perr=%b ferr=%b with no frame queued",
                 data, parity_err, frame_err);
      end else begin
        e = sb.pop_front();
        checks++;
        if (data !== e.d || parity_err !== e.pe || frame_err !== e.fe) begin
          errors++;
          $display("FAIL frame_result: got data=%h perr=%b ferr=%b required data=%h perr=%b ferr=%b",
                   data, parity_err, frame_err, e.d, e.pe, e.fe);
        end
        if (e.chk_lat) begin
          checks++;
          if (cycle - e.fall != 2 + C / 2 + 6 * C + 1) begin
            errors++;
            $display("FAIL latency: got %0d clks required %0d", cycle - e.fall, 2 + C / 2 + 6 * C + 1);
          end
        end
        last_data = e.d;
        last_pe   = e.pe;
        last_fe   = e.fe;
        $display("rx frame: data=%h parity_err=%b frame_err=%b at cycle %0d", data, parity_err, frame_err, cycle);
      end
    end
    prev_valid = valid;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input bit chk);
    exp_t e;
    e.d       = d;
    e.pe      = p ^ (^d);
    e.fe      = ~s;
    e.fall    = cycle;
    e.chk_lat = chk;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    #12;
    checks++;
    if (data !== 4'h0 || valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%h valid=%b perr=%b ferr=%b busy=%b required all 0",
               data, valid, parity_err, frame_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_good_frame();
    logic [3:0] d = 4'hB;
    align();
    send_frame(d, 1'b1, 1'b1, 1'b1);
    wait_drain(40);
    checks++;
    if (data2 !== d || parity_err2 !== (1'b1 ^ (^d) ^ 1'b1) || frame_err2 !== 1'b0) begin
      errors++;
      $display("FAIL odd_good_frame: data=%h perr=%b ferr=%b required data=%h perr=%b ferr=0",
               data2, parity_err2, frame_err2, d, 1'b1 ^ (^d) ^ 1'b1);
    end
  endtask

  task automatic test_parity_error();
    logic [3:0] d = 4'hB;
    align();
    send_frame(d, 1'b0, 1'b1, 1'b0);
    wait_drain(40);
    checks++;
    if (data2 !== d || parity_err2 !== (1'b0 ^ (^d) ^ 1'b1)) begin
      errors++;
      $display("FAIL odd_parity: data=%h perr=%b required data=%h perr=%b",
               data2, parity_err2, d, 1'b0 ^ (^d) ^ 1'b1);
    end
  endtask

  task automatic test_frame_error();
    int vc;
    align();
    send_frame(4'h6, 1'b0, 1'b0, 1'b0);
    wait_drain(40);
    vc = valid_count;
    rx = 1'b0;
    repeat (20 * C) @(posedge clk);
    #1;
    checks++;
    if (valid_count != vc || frame_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_low: valids=%0d ferr=%b busy=%b required valids=%0d ferr=1 busy=0",
               valid_count - vc, frame_err, busy, 0);
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(4'h1, 1'b1, 1'b1, 1'b1);
    wait_drain(40);
  endtask

  task automatic test_glitch();
    int vc = valid_count;
    align();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy=%b required 1", busy);
    end
    rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid_count != vc || data !== last_data ||
        parity_err !== last_pe || frame_err !== last_fe) begin
      errors++;
      $display("FAIL glitch_reject: busy=%b valids=%0d data=%h perr=%b ferr=%b required busy=0 valids=0 data=%h perr=%b ferr=%b",
               busy, valid_count - vc, data, parity_err, frame_err, last_data, last_pe, last_fe);
    end
  endtask

  task automatic test_reset_mid_frame();
    int vc = valid_count;
    align();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (C / 2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (data !== 4'h0 || valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_reset: data=%h valid=%b perr=%b ferr=%b busy=%b required all 0",
               data, valid, parity_err, frame_err, busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    checks++;
    if (valid_count != vc) begin
      errors++;
      $display("FAIL abandoned_frame: valids=%0d required 0", valid_count - vc);
    end
    align();
    send_frame(4'hF, 1'b0, 1'b1, 1'b1);
    wait_drain(40);
  endtask

  task automatic test_back_to_back();
    int vc = valid_count;
    align();
    send_frame(4'h0, 1'b0, 1'b1, 1'b1);
    send_frame(4'hF, 1'b0, 1'b1, 1'b1);
    send_frame(4'hA, 1'b0, 1'b1, 1'b1);
    wait_drain(40);
    checks++;
    if (valid_count - vc != 3) begin
      errors++;
      $display("FAIL back_to_back_count: valids=%0d required 3", valid_count - vc);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
